mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory port between the core's instruction fetch path (read-only) and its data path (read/write) for single-ported memory systems.
- Sits between simple_processor's imem/dmem req/ack interfaces and a single downstream memory port.
- Registered grant FSM, at most one outstanding transfer, and a watchdog that aborts stalled transfers.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 256, maximum number of cycles in BUSY waiting for mem_ack_i; 0 disables the watchdog

Ports:
clk_i  in  1  clock; all logic samples on the rising edge
rst_i  in  1  reset, synchronous, active-high
imem_req_i  in  1  fetch request; held until imem_ack_o
imem_addr_i  in  ADDR_WIDTH  fetch address
imem_rdata_o  out  DATA_WIDTH  fetch read data, valid while imem_ack_o
imem_ack_o  out  1  single-cycle fetch completion
dmem_req_i  in  1  data request; held until dmem_ack_o
dmem_we_i  in  1  data write enable
dmem_addr_i  in  ADDR_WIDTH  data address
dmem_wdata_i  in  DATA_WIDTH  data write data
dmem_rdata_o  out  DATA_WIDTH  data read data, valid while dmem_ack_o
dmem_ack_o  out  1  single-cycle data completion
mem_req_o  out  1  downstream request
mem_we_o  out  1  downstream write enable
mem_addr_o  out  ADDR_WIDTH  downstream address
mem_wdata_o  out  DATA_WIDTH  downstream write data
mem_rdata_i  in  DATA_WIDTH  downstream read data
mem_ack_i  in  1  downstream single-cycle completion
err_o  out  1  one-cycle pulse when the watchdog aborts a transfer

Behaviour:
- Reset:
  - rst_i high at a clock edge forces state IDLE and clears the timeout counter, err_o and the last-grant flag.
  - Applies even mid-transfer: mem_req_o is low from the next cycle, and a late mem_ack_i is ignored.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - mem_req_o=0.
  - If dmem_req_i is high, next state is BUSY_D; else if imem_req_i is high, next state is BUSY_I; otherwise stay in IDLE. This is fixed priority, data first.
- BUSY_x:
  - mem_req_o=1. mem_we_o, mem_addr_o and mem_wdata_o are muxed combinationally from the granted requester.
  - mem_we_o=0 in BUSY_I. mem_wdata_o is don't-care in BUSY_I.
  - Outputs are muxed, not latched; requesters hold their inputs stable until ack.
- Completion:
  - A cycle in BUSY_x with mem_ack_i=1 drives x_ack_o=mem_ack_i combinationally and passes mem_rdata_i to x_rdata_o.
  - Next state is IDLE.
  - Minimum latency from req to ack is 2 cycles (IDLE→BUSY, ack in the same cycle when memory acks combinationally).
  - Maximum throughput is one transfer per 2 cycles.
- Non-granted side: ack=0 and rdata=0 at all times.
- Requester drops req while granted (protocol violation):
  - The transfer still completes downstream.
  - The ack is forwarded only if req is still high, otherwise discarded.
- Watchdog:
  - The counter increments on each BUSY cycle without mem_ack_i.
  - When it reaches TIMEOUT_CYCLES, the block pulses err_o for 1 cycle, pulses the granted x_ack_o with rdata=0, and returns to IDLE.
  - Counter width is clog2(TIMEOUT_CYCLES+1); it clears on entry to BUSY.
  - mem_ack_i arriving in the same cycle as the timeout takes precedence: normal completion, no err_o.
- mem_ack_i in IDLE is ignored.
- All outputs are 0 in reset and in IDLE.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requests are high in IDLE, grant goes to the requester not served last.
  - The last-grant flag updates on every grant and resets to "imem", so the first tie goes to dmem.
- Undefined: fixed dmem-first priority as in Behaviour; the last-grant flag is not implemented.

Test Plan:
- Single fetch: imem_req_i=1, addr=0x1000, memory acks combinationally with data 0x12345678 → mem_req_o rises 1 cycle after req, imem_ack_o pulses with rdata 0x12345678, dmem_ack_o stays 0.
- Data write: dmem_req_i=1, we=1, addr=0x2004, wdata=0xDEADBEEF, memory acks after 3 wait cycles → mem_we_o=1, mem_addr_o=0x2004, mem_wdata_o=0xDEADBEEF held 4 cycles, dmem_ack_o pulses once.
- Contention: both requests held for 4 transfers → without the macro, dmem wins every grant while held; with MEM_ARB_ROUND_ROBIN_EN, grants alternate D,I,D,I.
- Timeout: TIMEOUT_CYCLES=8, dmem read with mem_ack_i never asserted → err_o and dmem_ack_o pulse together in the 8th BUSY cycle with rdata 0, then IDLE. A separate run with ack in exactly that cycle → no err_o.
- Reset mid-transfer: rst_i high during BUSY_I, then mem_ack_i pulses → no imem_ack_o, mem_req_o=0 next cycle, state IDLE.
- Dropped request: imem_req_i deasserted during BUSY_I before mem_ack_i → transfer completes downstream, imem_ack_o stays 0, next transfer grants normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares a single downstream memory port between an instruction-fetch
// requester (read-only) and a data requester (read/write). A registered
// grant FSM allows at most one outstanding transfer; a watchdog aborts a
// transfer that waits too long for the memory to acknowledge.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data requester wins every tie
//   defined   : on a tie the requester not served last wins; the
//               last-grant flag resets to "imem" so the first tie goes
//               to the data requester
//
// Parameters:
//   ADDR_WIDTH      address width of all ports
//   DATA_WIDTH      data width of all ports
//   TIMEOUT_CYCLES  BUSY cycles without mem_ack_i before the watchdog
//                   aborts the transfer; 0 disables the watchdog
//
// Ports:
//   clk_i, rst_i           clock (rising edge), synchronous active-high reset
//   imem_req_i/addr_i      fetch request, held until imem_ack_o
//   imem_rdata_o/ack_o     fetch read data and single-cycle completion
//   dmem_req_i/we_i/addr_i/wdata_i  data request, held until dmem_ack_o
//   dmem_rdata_o/ack_o     data read data and single-cycle completion
//   mem_req_o/we_o/addr_o/wdata_o   downstream request
//   mem_rdata_i/ack_i      downstream read data and single-cycle completion
//   err_o                  one-cycle pulse when the watchdog aborts

module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  imem_req_i,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  output logic                  imem_ack_o,

  input  logic                  dmem_req_i,
  input  logic                  dmem_we_i,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  dmem_ack_o,

  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i,

  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  // Counter is sized to hold TIMEOUT_CYCLES; a 1-bit stub keeps the
  // declaration legal when the watchdog is disabled.
  localparam bit WDOG_EN  = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W    = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_INT = WDOG_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_cnt;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_grantD;
  logic w_grantI;

  // The counter holds the number of completed BUSY cycles without an ack,
  // so the TIMEOUT_CYCLES-th BUSY cycle sees TIMEOUT_CYCLES-1. A real ack
  // in that same cycle wins over the abort.
  assign w_busy    = (r_state != ST_IDLE);
  assign w_timeout = WDOG_EN && w_busy && !mem_ack_i && (r_cnt == CNT_LAST);
  assign w_done    = w_busy && (mem_ack_i || w_timeout);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_lastD;

  // On a tie the data side only wins if it was not the last one served.
  assign w_grantD = dmem_req_i && (!imem_req_i || !r_lastD);
`else
  assign w_grantD = dmem_req_i;
`endif
  assign w_grantI = imem_req_i && !w_grantD;

  // State register, watchdog counter and (optionally) the last-grant flag.
  // The counter sits at zero whenever the FSM is idle or finishing, which
  // makes it start from zero on every entry to BUSY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_lastD <= 1'b0;
`endif
    end else begin
      r_state <= w_nextState;
      if (!w_busy || w_done || !WDOG_EN) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (r_state == ST_IDLE && w_nextState != ST_IDLE) begin
        r_lastD <= (w_nextState == ST_BUSY_D);
      end
`endif
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on ack or abort.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grantD) begin
          w_nextState = ST_BUSY_D;
        end else if (w_grantI) begin
          w_nextState = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (w_done) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output mux. The downstream request is driven straight from the granted
  // requester's inputs. Acks are only forwarded while the requester still
  // holds its request, so a dropped request silently swallows the ack. An
  // aborted transfer acks with zero read data.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    imem_ack_o   = 1'b0;
    imem_rdata_o = '0;
    dmem_ack_o   = 1'b0;
    dmem_rdata_o = '0;
    err_o        = w_timeout;
    case (r_state)
      ST_BUSY_I: begin
        mem_req_o  = 1'b1;
        mem_addr_o = imem_addr_i;
        if (imem_req_i) begin
          if (mem_ack_i) begin
            imem_ack_o   = 1'b1;
            imem_rdata_o = mem_rdata_i;
          end else if (w_timeout) begin
            imem_ack_o   = 1'b1;
          end
        end
      end
      ST_BUSY_D: begin
        mem_req_o   = 1'b1;
        mem_we_o    = dmem_we_i;
        mem_addr_o  = dmem_addr_i;
        mem_wdata_o = dmem_wdata_i;
        if (dmem_req_i) begin
          if (mem_ack_i) begin
            dmem_ack_o   = 1'b1;
            dmem_rdata_o = mem_rdata_i;
          end else if (w_timeout) begin
            dmem_ack_o   = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES=8. The memory
// side is driven by hand from the stimulus sequence. Inputs change 2 time
// units after a rising edge and outputs are compared 1 unit later, well
// away from the next edge.

module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          imem_req_i;
  logic [AW-1:0] imem_addr_i;
  logic [DW-1:0] imem_rdata_o;
  logic          imem_ack_o;
  logic          dmem_req_i;
  logic          dmem_we_i;
  logic [AW-1:0] dmem_addr_i;
  logic [DW-1:0] dmem_wdata_i;
  logic [DW-1:0] dmem_rdata_o;
  logic          dmem_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_i   (imem_req_i),
    .imem_addr_i  (imem_addr_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_ack_o   (imem_ack_o),
    .dmem_req_i   (dmem_req_i),
    .dmem_we_i    (dmem_we_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_wdata_i (dmem_wdata_i),
    .dmem_rdata_o (dmem_rdata_o),
    .dmem_ack_o   (dmem_ack_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk_i);
    #2;
  endtask

  // Drive the memory-side response, then let combinational outputs settle.
  task automatic applyStimulus(input logic ack, input logic [DW-1:0] rdata);
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic expD;

    rst_i        = 1'b1;
    imem_req_i   = 1'b0;
    imem_addr_i  = '0;
    dmem_req_i   = 1'b0;
    dmem_we_i    = 1'b0;
    dmem_addr_i  = '0;
    dmem_wdata_i = '0;
    mem_ack_i    = 1'b0;
    mem_rdata_i  = '0;

    // Reset state
    nextCycle();
    nextCycle();
    applyStimulus(1'b1, 32'hFFFF_FFFF);
    checkOutput("rst_mem_req", mem_req_o, 0);
    checkOutput("rst_imem_ack", imem_ack_o, 0);
    checkOutput("rst_dmem_ack", dmem_ack_o, 0);
    checkOutput("rst_err", err_o, 0);
    checkOutput("rst_imem_rdata", imem_rdata_o, 0);
    rst_i = 1'b0;
    applyStimulus(1'b0, '0);

    // Single fetch, memory acks combinationally
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_1000;
    applyStimulus(1'b0, '0);
    checkOutput("fetch_idle_req", mem_req_o, 0);
    nextCycle();
    applyStimulus(1'b1, 32'h1234_5678);
    checkOutput("fetch_mem_req", mem_req_o, 1);
    checkOutput("fetch_mem_addr", mem_addr_o, 32'h1000);
    checkOutput("fetch_mem_we", mem_we_o, 0);
    checkOutput("fetch_imem_ack", imem_ack_o, 1);
    checkOutput("fetch_imem_rdata", imem_rdata_o, 32'h1234_5678);
    checkOutput("fetch_dmem_ack", dmem_ack_o, 0);
    checkOutput("fetch_dmem_rdata", dmem_rdata_o, 0);
    nextCycle();
    imem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("fetch_after_req", mem_req_o, 0);
    checkOutput("fetch_after_ack", imem_ack_o, 0);

    // Data write, 3 wait cycles then ack
    dmem_req_i   = 1'b1;
    dmem_we_i    = 1'b1;
    dmem_addr_i  = 32'h0000_2004;
    dmem_wdata_i = 32'hDEAD_BEEF;
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i == 3, 32'h0);
      checkOutput("wr_mem_req", mem_req_o, 1);
      checkOutput("wr_mem_we", mem_we_o, 1);
      checkOutput("wr_mem_addr", mem_addr_o, 32'h2004);
      checkOutput("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      checkOutput("wr_dmem_ack", dmem_ack_o, (i == 3) ? 1 : 0);
      checkOutput("wr_err", err_o, 0);
      nextCycle();
    end
    dmem_req_i = 1'b0;
    dmem_we_i  = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("wr_after_req", mem_req_o, 0);
    checkOutput("wr_after_ack", dmem_ack_o, 0);

    // Contention: fresh reset so the last-grant flag starts at "imem"
    rst_i = 1'b1;
    nextCycle();
    rst_i       = 1'b0;
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_3000;
    dmem_req_i  = 1'b1;
    dmem_addr_i = 32'h0000_4000;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      expD = (k % 2 == 0);
`else
      expD = 1'b1;
`endif
      nextCycle();
      applyStimulus(1'b1, 32'hC0DE_0000 + k);
      checkOutput("cont_mem_addr", mem_addr_o, expD ? 32'h4000 : 32'h3000);
      checkOutput("cont_dmem_ack", dmem_ack_o, expD ? 1 : 0);
      checkOutput("cont_imem_ack", imem_ack_o, expD ? 0 : 1);
      checkOutput("cont_rdata", expD ? dmem_rdata_o : imem_rdata_o, 32'hC0DE_0000 + k);
      checkOutput("cont_other_rdata", expD ? imem_rdata_o : dmem_rdata_o, 0);
      nextCycle();
      applyStimulus(1'b0, '0);
      checkOutput("cont_idle_req", mem_req_o, 0);
    end
    imem_req_i = 1'b0;
    dmem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    nextCycle();

    // Timeout: dmem read, no ack, abort in the 8th BUSY cycle
    dmem_req_i  = 1'b1;
    dmem_addr_i = 32'h0000_5000;
    nextCycle();
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(1'b0, 32'hAAAA_5555);
      checkOutput("to_mem_req", mem_req_o, 1);
      checkOutput("to_err", err_o, (c == 8) ? 1 : 0);
      checkOutput("to_dmem_ack", dmem_ack_o, (c == 8) ? 1 : 0);
      checkOutput("to_dmem_rdata", dmem_rdata_o, 0);
      nextCycle();
    end
    dmem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("to_idle_req", mem_req_o, 0);
    checkOutput("to_idle_err", err_o, 0);
    nextCycle();

    // Ack arriving exactly in the timeout cycle wins
    dmem_req_i = 1'b1;
    nextCycle();
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(c == 8, 32'h0BAD_F00D);
      checkOutput("toack_err", err_o, 0);
      checkOutput("toack_dmem_ack", dmem_ack_o, (c == 8) ? 1 : 0);
      if (c == 8) begin
        checkOutput("toack_rdata", dmem_rdata_o, 32'h0BAD_F00D);
      end
      nextCycle();
    end
    dmem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("toack_idle_req", mem_req_o, 0);
    nextCycle();

    // Reset mid-transfer, late ack ignored
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_6000;
    nextCycle();
    applyStimulus(1'b0, '0);
    checkOutput("rstmid_busy_req", mem_req_o, 1);
    rst_i = 1'b1;
    nextCycle();
    rst_i = 1'b0;
    applyStimulus(1'b1, 32'h5555_AAAA);
    checkOutput("rstmid_mem_req", mem_req_o, 0);
    checkOutput("rstmid_imem_ack", imem_ack_o, 0);
    checkOutput("rstmid_rdata", imem_rdata_o, 0);
    imem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    nextCycle();

    // Dropped request: transfer finishes downstream, ack discarded
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_7000;
    nextCycle();
    imem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("drop_mem_req", mem_req_o, 1);
    checkOutput("drop_imem_ack", imem_ack_o, 0);
    nextCycle();
    applyStimulus(1'b1, 32'h1111_2222);
    checkOutput("drop_ack_mem_req", mem_req_o, 1);
    checkOutput("drop_ack_imem_ack", imem_ack_o, 0);
    checkOutput("drop_ack_rdata", imem_rdata_o, 0);
    nextCycle();
    imem_req_i  = 1'b1;
    imem_addr_i = 32'h0000_7004;
    applyStimulus(1'b0, '0);
    checkOutput("drop_idle_req", mem_req_o, 0);
    nextCycle();
    applyStimulus(1'b1, 32'h3333_4444);
    checkOutput("drop_next_addr", mem_addr_o, 32'h7004);
    checkOutput("drop_next_ack", imem_ack_o, 1);
    checkOutput("drop_next_rdata", imem_rdata_o, 32'h3333_4444);
    nextCycle();
    imem_req_i = 1'b0;
    applyStimulus(1'b0, '0);
    checkOutput("drop_final_req", mem_req_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
